// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file for the pipelined datapath.
//
// NRD combinational read ports and two write ports: port 0 for EX
// writeback and port 1 for MEM/load writeback. A write is visible on the
// read ports in the same cycle through a bypass, and port 1 takes
// precedence over port 0. A per-register busy scoreboard is used for hazard
// detection. After reset an init walker spends exactly NREG cycles clearing
// the array, or loading the test preset, before init_done rises.
//
// Build option:
//   REGFILE_PRESET_EN  when defined, the init walk loads the test preset
//                      (r1..r9 = 1,1,4,3,2,1,6,4,2; all others 0).
//                      When undefined, the walk writes zero everywhere.
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   rst                 asynchronous reset, active low
//   init_done           high once the init walk is finished
//   we0/waddr0/wdata0   write port 0 (EX writeback)
//   we1/waddr1/wdata1   write port 1 (MEM writeback); wins on an address clash
//   raddr               packed read addresses, port k = raddr[k*ASIZE +: ASIZE]
//   rdata               packed read data,      port k = rdata[k*DSIZE +: DSIZE]
//   claim_en/claim_addr mark a register busy (a producer has been issued)
//   busy                scoreboard, one bit per register
module regfile_mp #(
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 5,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   we0,
  input  logic [ASIZE-1:0]       waddr0,
  input  logic [DSIZE-1:0]       wdata0,
  input  logic                   we1,
  input  logic [ASIZE-1:0]       waddr1,
  input  logic [DSIZE-1:0]       wdata1,
  input  logic [NRD*ASIZE-1:0]   raddr,
  output logic [NRD*DSIZE-1:0]   rdata,
  input  logic                   claim_en,
  input  logic [ASIZE-1:0]       claim_addr,
  output logic [NREG-1:0]        busy
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  // One extra bit so that NREG == 2**ASIZE is still representable.
  localparam logic [ASIZE:0]   NREG_A = (ASIZE+1)'(NREG);
  localparam logic [ASIZE-1:0] LAST_A = ASIZE'(NREG-1);

  state_e           state_q;
  logic [ASIZE-1:0] ptr_q;
  logic             init_done_q;
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [DSIZE-1:0] mem_q [NREG];

  logic run;
  logic w0_ok;
  logic w1_ok;
  logic claim_ok;

  // An address is usable for writes, claims and reads when it is inside the
  // file and is not the hardwired-zero r0.
  function automatic logic addr_ok(input logic [ASIZE-1:0] a);
    return ({1'b0, a} < NREG_A) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

`ifdef REGFILE_PRESET_EN
  function automatic logic [DSIZE-1:0] init_val(input logic [ASIZE-1:0] a);
    logic [3:0] v;
    v = 4'd0;
    case (int'(a))
      1:       v = 4'd1;
      2:       v = 4'd1;
      3:       v = 4'd4;
      4:       v = 4'd3;
      5:       v = 4'd2;
      6:       v = 4'd1;
      7:       v = 4'd6;
      8:       v = 4'd4;
      9:       v = 4'd2;
      default: v = 4'd0;
    endcase
    return DSIZE'(v);
  endfunction
`endif

  assign run      = (state_q == S_RUN);
  assign w0_ok    = run && we0 && addr_ok(waddr0);
  assign w1_ok    = run && we1 && addr_ok(waddr1);
  assign claim_ok = run && claim_en && addr_ok(claim_addr);

  // Control: init walk, init_done and the scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST_A) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
            ptr_q       <= '0;
          end
        end
        S_RUN:   busy_q  <= busy_d;
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Storage has no reset; the walk defines every entry before RUN.
  // Port 1 is written last so it wins an address clash.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
`ifdef REGFILE_PRESET_EN
      mem_q[ptr_q] <= init_val(ptr_q);
`else
      mem_q[ptr_q] <= '0;
`endif
    end else begin
      if (w0_ok) mem_q[waddr0] <= wdata0;
      if (w1_ok) mem_q[waddr1] <= wdata1;
    end
  end

  // Clears come before the set, so a claim in the same cycle as a write to
  // the same register leaves it busy (a new producer is outstanding).
  always_comb begin
    busy_d = busy_q;
    if (w0_ok)    busy_d[waddr0]     = 1'b0;
    if (w1_ok)    busy_d[waddr1]     = 1'b0;
    if (claim_ok) busy_d[claim_addr] = 1'b1;
  end

  // Read ports: zero during INIT, for out-of-range addresses and for r0.
  // Otherwise the port 1 bypass, then the port 0 bypass, then the array.
  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (run && addr_ok(raddr[k*ASIZE +: ASIZE])) begin
        if (w1_ok && (waddr1 == raddr[k*ASIZE +: ASIZE]))
          rdata[k*DSIZE +: DSIZE] = wdata1;
        else if (w0_ok && (waddr0 == raddr[k*ASIZE +: ASIZE]))
          rdata[k*DSIZE +: DSIZE] = wdata0;
        else
          rdata[k*DSIZE +: DSIZE] = mem_q[raddr[k*ASIZE +: ASIZE]];
      end
    end
  end

  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp with the default parameters (32 x 32 bit
// registers, 2 read ports, r0 hardwired to zero). The stimulus process
// drives inputs just after each rising edge and queues the expected output
// values. The monitor pops the queue on every falling edge and compares.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int NP = 2;

`ifdef REGFILE_PRESET_EN
  localparam logic [31:0] R3_EXP = 32'd4;
  localparam logic [31:0] R7_EXP = 32'd6;
`else
  localparam logic [31:0] R3_EXP = 32'd0;
  localparam logic [31:0] R7_EXP = 32'd0;
`endif

  localparam int SEL_RD0  = 0;
  localparam int SEL_RD1  = 1;
  localparam int SEL_DONE = 2;
  localparam int SEL_BUSY = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NP*AW-1:0] raddr;
  logic [NP*DW-1:0] rdata;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;
  logic [NR-1:0]    busy;

  regfile_mp #(
    .DSIZE  (DW),
    .ASIZE  (AW),
    .NREG   (NR),
    .NRD    (NP),
    .ZERO_R0(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .raddr     (raddr),
    .rdata     (rdata),
    .claim_en  (claim_en),
    .claim_addr(claim_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  exp_t        it;
  logic [31:0] act;

  // Monitor: everything queued during the current cycle is checked here.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      it = sb.pop_front();
      case (it.sel)
        SEL_RD0:  act = rdata[31:0];
        SEL_RD1:  act = rdata[63:32];
        SEL_DONE: act = {31'b0, init_done};
        default:  act = busy;
      endcase
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [31:0] e);
    sb.push_back('{n, s, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    set_rd(5'd3, 5'd3);
    tick();
    tick();
    chk("reset_done", SEL_DONE, 32'd0);
    chk("reset_busy", SEL_BUSY, 32'd0);
    chk("reset_rd0",  SEL_RD0,  32'd0);
    tick();

    // Test 1: init walk. Writes and claims of r3 are driven the whole time
    // and must be ignored.
    rst = 1'b1;
    for (int i = 1; i <= NR; i++) begin
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD;
      claim_en = 1'b1; claim_addr = 5'd3;
      chk($sformatf("init_done_c%0d", i), SEL_DONE, 32'd0);
      chk($sformatf("init_rd0_c%0d", i),  SEL_RD0,  32'd0);
      tick();
    end
    idle();
    chk("init_done_c33", SEL_DONE, 32'd1);
    chk("init_r3",       SEL_RD0,  R3_EXP);
    chk("init_busy",     SEL_BUSY, 32'd0);
    tick();

    // Test 2: same-cycle bypass, then the stored value.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hA5A5;
    set_rd(5'd5, 5'd3);
    chk("byp_w0_r5", SEL_RD0, 32'hA5A5);
    chk("byp_r3",    SEL_RD1, R3_EXP);
    tick();
    idle();
    chk("stored_r5", SEL_RD0, 32'hA5A5);
    tick();

    // Test 3: dual write to r7, port 1 wins; port 0 alone bypasses too.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    set_rd(5'd7, 5'd5);
    chk("dual_byp_r7", SEL_RD0, 32'h22);
    chk("dual_r5",     SEL_RD1, 32'hA5A5);
    tick();
    idle();
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h33;
    set_rd(5'd7, 5'd8);
    chk("dual_stored_r7", SEL_RD0, 32'h22);
    chk("byp_w0_r8",      SEL_RD1, 32'h33);
    tick();
    idle();
    chk("stored_r8", SEL_RD1, 32'h33);
    tick();

    // Test 4: r0 is never written, bypassed or claimed.
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF;
    claim_en = 1'b1; claim_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    chk("r0_byp_rd0", SEL_RD0, 32'd0);
    chk("r0_byp_rd1", SEL_RD1, 32'd0);
    tick();
    idle();
    chk("r0_stored", SEL_RD0, 32'd0);
    chk("r0_busy",   SEL_BUSY, 32'd0);
    tick();

    // Test 5: scoreboard set, set-wins, clear.
    claim_en = 1'b1; claim_addr = 5'd10;
    tick();
    idle();
    chk("claim_r10", SEL_BUSY, 32'h0000_0400);
    claim_en = 1'b1; claim_addr = 5'd10;
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h55;
    set_rd(5'd10, 5'd0);
    chk("claim_wr_byp", SEL_RD0, 32'h55);
    tick();
    idle();
    chk("claim_wr_busy", SEL_BUSY, 32'h0000_0400);
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h66;
    tick();
    idle();
    chk("wr_clear_busy", SEL_BUSY, 32'd0);
    chk("wr_r10",        SEL_RD0,  32'h66);
    tick();

    // Test 6: reset from RUN clears busy; reset in mid-walk restarts it.
    claim_en = 1'b1; claim_addr = 5'd12;
    tick();
    idle();
    chk("claim_r12", SEL_BUSY, 32'h0000_1000);
    tick();
    rst = 1'b0;
    chk("rst_run_done", SEL_DONE, 32'd0);
    chk("rst_run_busy", SEL_BUSY, 32'd0);
    chk("rst_run_rd0",  SEL_RD0,  32'd0);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      chk($sformatf("walk1_done_c%0d", i), SEL_DONE, 32'd0);
      tick();
    end
    rst = 1'b0;
    chk("rst_walk_done", SEL_DONE, 32'd0);
    tick();
    rst = 1'b1;
    set_rd(5'd7, 5'd3);
    for (int i = 1; i <= NR; i++) begin
      chk($sformatf("walk2_done_c%0d", i), SEL_DONE, 32'd0);
      chk($sformatf("walk2_rd1_c%0d", i),  SEL_RD1,  32'd0);
      tick();
    end
    chk("walk2_done_c33", SEL_DONE, 32'd1);
    chk("walk2_r7",       SEL_RD0,  R7_EXP);
    chk("walk2_r3",       SEL_RD1,  R3_EXP);
    chk("walk2_busy",     SEL_BUSY, 32'd0);
    tick();
    tick();

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
